// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg: stall vector encodings, FSM states and exception vector default shared by pipe_ctrl.
package pipe_ctrl_pkg;
  localparam int STALL_W = 6;
  localparam logic STOP = 1'b1;
  localparam logic NO_STOP = 1'b0;
  localparam logic [STALL_W-1:0] STALL_MEM  = 6'b011111;
  localparam logic [STALL_W-1:0] STALL_EX   = 6'b001111;
  localparam logic [STALL_W-1:0] STALL_ID   = 6'b000111;
  localparam logic [STALL_W-1:0] STALL_IF   = 6'b000011;
  localparam logic [STALL_W-1:0] STALL_ALL  = {STALL_W{STOP}};
  localparam logic [STALL_W-1:0] STALL_NONE = {STALL_W{NO_STOP}};
  localparam logic [31:0] EXC_VECTOR_DEFAULT = 32'hBFC00380;
  typedef enum logic [1:0] {RUN, DRAIN, FLUSH} state_e;
endpackage

// File: rtl/pipe_wdt.sv
// pipe_wdt: saturating count of consecutive PC-stalled cycles with a sticky timeout flag.
module pipe_wdt #(
  parameter int LIMIT = 1023,
  parameter int W = 10
) (
  input  logic clk,
  input  logic reset,
  input  logic stall_pc,
  output logic timeout
);
  logic [W-1:0] cnt_q, cnt_d;
  logic timeout_q, timeout_d;
  always_comb begin
    cnt_d = !stall_pc ? '0 : (cnt_q == W'(LIMIT) ? cnt_q : cnt_q + 1'b1);
    timeout_d = timeout_q | (cnt_d == W'(LIMIT));
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
      timeout_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      timeout_q <= timeout_d;
    end
  end
  assign timeout = timeout_q;
endmodule

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: stall merging and exception/ERET redirect sequencing; define PIPE_CTRL_WDT_EN to build the stall watchdog.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter logic [31:0] EXC_VECTOR = EXC_VECTOR_DEFAULT,
  parameter int WDT_LIMIT = 1023,
  parameter int WDT_W = 10
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               stallreq_if,
  input  logic               stallreq_id,
  input  logic               stallreq_ex,
  input  logic               stallreq_mem,
  input  logic               exc_valid,
  input  logic               exc_is_eret,
  input  logic [31:0]        cp0_epc,
  output logic [STALL_W-1:0] stall,
  output logic               flush,
  output logic [31:0]        new_pc,
  output logic               wdt_timeout
);
  state_e state_q, state_d;
  logic [31:0] target_q, target_d;
  logic [STALL_W-1:0] req_stall;
  if (2 ** WDT_W <= WDT_LIMIT) begin : g_bad_wdt
    $error("WDT_W too narrow for WDT_LIMIT");
  end
  always_comb begin
    req_stall = stallreq_mem ? STALL_MEM : stallreq_ex ? STALL_EX :
                stallreq_id ? STALL_ID : stallreq_if ? STALL_IF : STALL_NONE;
    stall = state_q == RUN ? (exc_valid ? STALL_ALL : req_stall) :
            state_q == DRAIN ? STALL_ALL : STALL_NONE;
    state_d = state_q == RUN ? (exc_valid ? (stallreq_if ? DRAIN : FLUSH) : RUN) :
              state_q == DRAIN ? (stallreq_if ? DRAIN : FLUSH) : RUN;
    target_d = (state_q == RUN && exc_valid) ? (exc_is_eret ? cp0_epc : EXC_VECTOR) : target_q;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= RUN;
      target_q <= '0;
    end else begin
      state_q <= state_d;
      target_q <= target_d;
    end
  end
  assign flush = state_q == FLUSH;
  assign new_pc = target_q;
`ifdef PIPE_CTRL_WDT_EN
  pipe_wdt #(.LIMIT(WDT_LIMIT), .W(WDT_W)) u_wdt (
    .clk(clk),
    .reset(reset),
    .stall_pc(stall[0]),
    .timeout(wdt_timeout)
  );
`else
  assign wdt_timeout = 1'b0;
`endif
endmodule

// File: doc/pipe_ctrl.md
# pipe_ctrl

Central pipeline control unit for the five-stage core. It merges per-stage stall requests into the `stall[5:0]` vector consumed by every pipeline register (pc, if_id, id_ex, ex_mem, mem_wb). It also sequences exception and ERET redirects: it freezes the pipe, waits for any in-flight instruction fetch to drain, then issues a one-cycle `flush` with the redirect PC. An optional watchdog flags a pipeline stuck in stall.

## Interface
Parameters:
- `EXC_VECTOR`, default 32'hBFC00380: redirect target for all non-ERET exceptions.
- `WDT_LIMIT`, default 1023: consecutive stalled cycles before timeout. Used only with the watchdog compiled in.
- `WDT_W`, default 10: watchdog counter width. Must satisfy 2^WDT_W > WDT_LIMIT.

Ports:
- `clk`  in  1  clock.
- `reset`  in  1  synchronous, active-high.
- `stallreq_if`  in  1  instruction fetch outstanding (icache miss or bus wait).
- `stallreq_id`  in  1  load-use hazard.
- `stallreq_ex`  in  1  multi-cycle EX op (div/mul) busy.
- `stallreq_mem`  in  1  data access outstanding.
- `exc_valid`  in  1  MEM stage reports a committed exception or ERET this cycle.
- `exc_is_eret`  in  1  qualifies `exc_valid`.
- `cp0_epc`  in  32  EPC value, sampled with `exc_valid`.
- `stall`  out  6  bit0 PC, 1 IF/ID, 2 ID/EX, 3 EX/MEM, 4 MEM/WB, 5 WB; 1 = hold.
- `flush`  out  1  one-cycle pulse; all pipeline registers clear.
- `new_pc`  out  32  redirect PC; valid while `flush`=1.
- `wdt_timeout`  out  1  sticky watchdog flag.

## Operation
- FSM states: RUN, DRAIN, FLUSH. Reset enters RUN.
- In RUN with `exc_valid`=0, `stall` is combinational. The highest-priority request wins:
  - mem: 6'b011111
  - ex: 6'b001111
  - id: 6'b000111
  - if: 6'b000011
  - none: 6'b000000
- Each downstream register bubbles when `stall[k]`=1 and `stall[k+1]`=0.
- RUN with `exc_valid`=1:
  - `stall` = 6'b111111 this cycle.
  - Latch the target: `cp0_epc` if `exc_is_eret`, else `EXC_VECTOR`.
  - Next state is DRAIN if `stallreq_if`=1, otherwise FLUSH.
  - `exc_valid` has priority over all stall requests.
- DRAIN: `stall` = 6'b111111. Stay while `stallreq_if`=1, then go to FLUSH.
- FLUSH: `flush`=1, `new_pc`=latched target, `stall`=0. Always returns to RUN.
- `exc_valid` in DRAIN or FLUSH is ignored; the flush discards the source instruction.
- `new_pc` is registered and holds its value outside FLUSH. Consumers qualify it with `flush`.

## Timing
- Reset values: state RUN, `stall`=0, `flush`=0, `new_pc`=0, `wdt_timeout`=0, watchdog counter 0.
- Stall latency: 0 cycles, combinational from requests in RUN.
- Exception latency:
  - Exception in cycle N with no fetch outstanding: `flush` in cycle N+1.
  - With a fetch outstanding: `flush` in the cycle after `stallreq_if` first samples 0.
- `flush` is always exactly 1 cycle wide. Back-to-back exceptions are at least 2 cycles apart.
- Reset asserted in DRAIN or FLUSH: the next cycle is RUN with no flush, and the latched target is cleared.
- Stall requests are ignored in DRAIN and FLUSH; the stall vector is fully state-driven there.

## Configuration
- `PIPE_CTRL_WDT_EN` defined:
  - A WDT_W-bit counter increments on each cycle with `stall[0]`=1 and clears on any cycle with `stall[0]`=0.
  - When the count reaches `WDT_LIMIT`, `wdt_timeout` sets and stays set until reset. The counter saturates.
- Undefined: no counter is built and `wdt_timeout` is tied to 0.

## Structure
- Shared package/defines: stall vector width, the stall pattern constants (STALL_MEM/EX/ID/IF/ALL/NONE), the FSM state encoding, and the `EXC_VECTOR` default. Stop/NoStop encodings match the existing pipeline-register defines.
- Sub-module: `pipe_wdt` holds the watchdog counter and sticky flag. Instantiate it only under `PIPE_CTRL_WDT_EN`.
- Remaining logic (priority encoder, FSM, target latch) stays flat.

## Test plan
- Priority: assert `stallreq_id`=1 and `stallreq_mem`=1 together → `stall`=6'b011111. Drop mem → 6'b000111 in the same cycle.
- Exception, no fetch pending: `exc_valid`=1, `exc_is_eret`=0 at cycle N → `stall`=6'b111111 at N. At N+1, `flush`=1, `new_pc`=32'hBFC00380, `stall`=0. At N+2, `flush`=0.
- ERET with drain:
  - Stimulus: `exc_is_eret`=1, `cp0_epc`=32'h80001234, `stallreq_if` high for 3 cycles after N.
  - Response: DRAIN for 3 cycles with `stall`=6'b111111, then a single `flush` with `new_pc`=32'h80001234.
- Ignored exception: second `exc_valid` during DRAIN → only one flush pulse, with the first target.
- Reset mid-DRAIN → next cycle `stall`=0, `flush`=0, `new_pc`=0, and no flush afterwards.
- Watchdog (macro on, `WDT_LIMIT`=8):
  - Hold `stallreq_ex` for 8 cycles → `wdt_timeout` rises and stays high after the request drops.
  - Hold `stallreq_ex` for 7 cycles, release, then 7 more → no timeout.
